// File: rtl/tape_capture_pkg.sv
// Shared types and timing helpers for the cassette tape-out capture block.
package tape_pkg;

    typedef enum logic [2:0] {
        IDLE,
        IDLE_WAIT,
        DATA,
        PARITY,
        STOP
    } tape_state_t;

    // Converts a duration in microseconds to whole clock cycles, rounded down.
    function automatic int unsigned us_to_cycles(input int unsigned clk_hz, input int unsigned us);
        longint unsigned c;
        c = (64'(clk_hz) * 64'(us)) / 64'd1000000;
        return 32'(c);
    endfunction

endpackage

// File: rtl/tape_capture_if.sv
// Tape-in / capture-RAM-out signal bundle for tape_capture.
interface tape_capture_if #(
    parameter int unsigned ADDR_W = 16
) ();
    logic              arm;
    logic              relay;
    logic              tape_out;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [ADDR_W:0]   byte_count;
    logic              parity_err;
    logic              overflow;
    logic              busy;

    // wr_en is a single-cycle strobe with no back-pressure: the capture RAM must
    // accept wr_addr/wr_data on every cycle wr_en is high.
    modport master (
        output arm, relay, tape_out,
        input  wr_en, wr_addr, wr_data, byte_count, parity_err, overflow, busy
    );

    modport slave (
        input  arm, relay, tape_out,
        output wr_en, wr_addr, wr_data, byte_count, parity_err, overflow, busy
    );
endinterface

// File: rtl/tape_capture_period_meter.sv
// Synchronises tape_out, times rising-edge-to-rising-edge periods and classifies
// each accepted period as a short (1) or long (0) bit; flags line idle.
module tape_period_meter
    import tape_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 24000000,
    parameter int unsigned MIN_US   = 100,
    parameter int unsigned SPLIT_US = 312,
    parameter int unsigned IDLE_US  = 1000
) (
    input  logic i_clk_sys,
    input  logic i_reset,
    input  logic i_tape_out,
    output logic o_bit_valid,
    output logic o_bit_val,
    output logic o_idle
);

    localparam logic [16:0] MIN_C   = 17'(us_to_cycles(CLK_HZ, MIN_US));
    localparam logic [16:0] SPLIT_C = 17'(us_to_cycles(CLK_HZ, SPLIT_US));
    localparam logic [16:0] IDLE_C  = 17'(us_to_cycles(CLK_HZ, IDLE_US));
    localparam logic [16:0] IDLE_M1 = IDLE_C - 17'd1;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    logic [16:0] r_cnt;

    logic w_rise;
    logic w_glitch;
    logic w_sat;
    logic w_accept;

    assign w_rise   = r_sync2 & ~r_prev;
    assign w_glitch = (r_cnt < MIN_C);
    assign w_sat    = (r_cnt >= IDLE_C);
    assign w_accept = w_rise & ~w_glitch;

    // The counter is cleared to 1 so that its value on the next edge equals the
    // full cycle length in clocks.
    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_tape_out;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (w_accept) begin
                r_cnt <= 17'd1;
            end else if (!w_sat) begin
                r_cnt <= r_cnt + 17'd1;
            end
        end
    end

    // An edge arriving after a saturated (idle) period only re-times the line;
    // the silence before it is not a bit.
    assign o_bit_valid = w_accept & ~w_sat;
    assign o_bit_val   = (r_cnt < SPLIT_C);
    assign o_idle      = (r_cnt == IDLE_M1) & ~w_accept;

endmodule

// File: rtl/tape_capture.sv
// Frames classified tape bits into Oric fast-format bytes (start 0, 8 data LSB
// first, odd parity, stop 1s) and writes them to the capture RAM.
module tape_capture
    import tape_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 24000000,
    parameter int unsigned MIN_US   = 100,
    parameter int unsigned SPLIT_US = 312,
    parameter int unsigned IDLE_US  = 1000,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic           i_clk_sys,
    input  logic           i_reset,
    tape_capture_if.slave  bus,
    output tape_state_t    o_dbg_state
);

    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    tape_state_t       r_state;
    tape_state_t       w_state_nxt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_nxt;
    logic [2:0]        r_idx;
    logic [2:0]        w_idx_nxt;
    logic              r_arm_d;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic [ADDR_W:0]   r_count;
    logic              r_parity_err;
    logic              r_overflow;

    logic w_bit_valid;
    logic w_bit_val;
    logic w_idle;
    logic w_run;
    logic w_arm_rise;
    logic w_set_perr;
    logic w_do_write;

    tape_period_meter #(
        .CLK_HZ  (CLK_HZ),
        .MIN_US  (MIN_US),
        .SPLIT_US(SPLIT_US),
        .IDLE_US (IDLE_US)
    ) u_meter (
        .i_clk_sys  (i_clk_sys),
        .i_reset    (i_reset),
        .i_tape_out (bus.tape_out),
        .o_bit_valid(w_bit_valid),
        .o_bit_val  (w_bit_val),
        .o_idle     (w_idle)
    );

    assign w_run      = bus.relay & bus.arm;
    assign w_arm_rise = bus.arm & ~r_arm_d;

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        w_set_perr  = 1'b0;
        w_do_write  = 1'b0;
        if (!w_run || w_arm_rise || w_idle) begin
            w_state_nxt = IDLE;
        end else if (w_bit_valid) begin
            unique case (r_state)
                IDLE, IDLE_WAIT: begin
                    if (!w_bit_val) begin
                        w_state_nxt = DATA;
                        w_idx_nxt   = 3'd0;
                    end
                end
                DATA: begin
                    w_shift_nxt = {w_bit_val, r_shift[7:1]};
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    w_set_perr  = ~((^r_shift) ^ w_bit_val);
                    w_state_nxt = STOP;
                end
                STOP: begin
                    // A 0 here is a framing error; it is not taken as a new start bit.
                    if (w_bit_val) begin
                        w_do_write  = 1'b1;
                        w_state_nxt = IDLE_WAIT;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_idx        <= '0;
            r_arm_d      <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_count      <= '0;
            r_parity_err <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_idx   <= w_idx_nxt;
            r_arm_d <= bus.arm;
            r_wr_en <= 1'b0;
            if (w_arm_rise) begin
                r_count      <= '0;
                r_parity_err <= 1'b0;
                r_overflow   <= 1'b0;
            end else begin
                if (w_set_perr) begin
                    r_parity_err <= 1'b1;
                end
                if (w_do_write) begin
                    if (r_count == FULL) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_count[ADDR_W-1:0];
                        r_wr_data <= r_shift;
                        r_count   <= r_count + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;
    assign bus.byte_count = r_count;
    assign bus.parity_err = r_parity_err;
    assign bus.overflow   = r_overflow;
    assign bus.busy       = (r_state != IDLE);
    assign o_dbg_state    = r_state;

endmodule
